// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction constants for the counter and its downstream converter.
// Pure declarations: no state, no latency, no flow control.
package gray_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Up to 32 bits; callers zero-extend narrower values and take the low bits of the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/b2g.sv
// Combinational binary-to-Gray mapper; exact inverse of the downstream Gray-to-binary converter.
// Zero latency; no flow control.
module b2g #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with clear, load and terminal-count flag; binary count kept alongside.
// 1-cycle latency from clr/load/en to all outputs; no backpressure, every enabled cycle steps.
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               WRAP        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_BIN    = '1;
  localparam logic [WIDTH-1:0] MIN_BIN    = '0;
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_tc;

  always_comb begin
    next_bin = bin;
    next_tc  = 1'b0;
    if (clr) begin
      next_bin = RESET_VALUE;
    end else if (load) begin
      next_bin = load_bin;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (bin == MAX_BIN) begin
          // Terminal step: wraps to zero, or holds at the limit when saturating.
          next_tc  = 1'b1;
          next_bin = (WRAP != 0) ? MIN_BIN : MAX_BIN;
        end else begin
          next_bin = bin + 1'b1;
        end
      end else begin
        if (bin == MIN_BIN) begin
          next_tc  = 1'b1;
          next_bin = (WRAP != 0) ? MAX_BIN : MIN_BIN;
        end else begin
          next_bin = bin - 1'b1;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both registers always agree.
  b2g #(.WIDTH(WIDTH)) u_b2g (
    .bin  (next_bin),
    .gray (next_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= RESET_VALUE;
      gray <= RESET_GRAY;
      tc   <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= next_gray;
      tc   <= next_tc;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Drives a wrapping and a saturating 4-bit counter with shared stimulus and checks both
// against a counting model and a reflected-binary Gray table.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_bin = 4'd0;
  logic       en = 1'b0;
  logic       up = 1'b1;

  logic [3:0] gray_w, bin_w, gray_s, bin_s;
  logic       tc_w, tc_s;

  int checks = 0;
  int failures = 0;

  int mw = 0, ms = 0;
  logic exp_tw = 1'b0, exp_ts = 1'b0;
  int gtab [16];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP(1), .RESET_VALUE(4'd0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
    .en(en), .up(up), .gray(gray_w), .bin(bin_w), .tc(tc_w)
  );

  gray_counter #(.WIDTH(4), .WRAP(0), .RESET_VALUE(4'd0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
    .en(en), .up(up), .gray(gray_s), .bin(bin_s), .tc(tc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " wrap.bin"},  32'(bin_w),  32'(mw));
    chk({tag, " wrap.gray"}, 32'(gray_w), 32'(gtab[mw]));
    chk({tag, " wrap.tc"},   32'(tc_w),   32'(exp_tw));
    chk({tag, " sat.bin"},   32'(bin_s),  32'(ms));
    chk({tag, " sat.gray"},  32'(gray_s), 32'(gtab[ms]));
    chk({tag, " sat.tc"},    32'(tc_s),   32'(exp_ts));
  endtask

  // One clock of stimulus: apply inputs just after a falling edge, advance the model,
  // then compare on the next falling edge.
  task automatic cycle(input string tag, input logic c, input logic l, input logic [3:0] lb,
                       input logic e, input logic u);
    logic [3:0] pgw, pgs;
    int ow, os;
    bit stepped;
    clr = c; load = l; load_bin = lb; en = e; up = u;
    pgw = gray_w; pgs = gray_s; ow = mw; os = ms;
    stepped = 1'b0;
    exp_tw = 1'b0; exp_ts = 1'b0;
    if (c) begin
      mw = 0; ms = 0;
    end else if (l) begin
      mw = int'(lb); ms = int'(lb);
    end else if (e) begin
      stepped = 1'b1;
      if (u) begin
        exp_tw = (mw == 15); mw = (mw + 1) % 16;
        exp_ts = (ms == 15); if (ms < 15) ms++;
      end else begin
        exp_tw = (mw == 0); mw = (mw + 15) % 16;
        exp_ts = (ms == 0); if (ms > 0) ms--;
      end
    end
    @(negedge clk);
    check_all(tag);
    if (stepped) begin
      chk({tag, " wrap.flips"}, 32'($countones(gray_w ^ pgw)), (mw != ow) ? 32'd1 : 32'd0);
      chk({tag, " sat.flips"},  32'($countones(gray_s ^ pgs)), (ms != os) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // Reflected-binary construction: mirror the existing list and set the next bit.
    gtab[0] = 0;
    for (int len = 1; len < 16; len *= 2)
      for (int i = 0; i < len; i++)
        gtab[2 * len - 1 - i] = gtab[i] + len;

    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      cycle("count_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      if (mw == 11) chk("gray_of_1011", 32'(gray_w), 32'b1110);
    end
    chk("wrap_to_zero.bin", 32'(bin_w), 32'd0);
    chk("wrap_to_zero.tc", 32'(tc_w), 32'd1);
    cycle("idle_after_wrap", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    cycle("wrap_down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("wrap_down.gray", 32'(gray_w), 32'b1000);
    cycle("load_pri", 1'b0, 1'b1, 4'b0111, 1'b1, 1'b1);
    chk("load_pri.gray", 32'(gray_w), 32'b0100);
    cycle("clr_pri", 1'b1, 1'b1, 4'b0111, 1'b1, 1'b1);

    cycle("load_14", 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle("sat_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("sat_hold.gray", 32'(gray_s), 32'b1000);
    cycle("sat_down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

    cycle("load_5", 1'b0, 1'b1, 4'b0101, 1'b0, 1'b1);
    cycle("hold_5", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    mw = 0; ms = 0; exp_tw = 1'b0; exp_ts = 1'b0;
    check_all("async_reset");
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle("resume", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    for (int k = 0; k < 400; k++) begin
      cycle("random", ($urandom_range(15) == 0), ($urandom_range(7) == 0), 4'($urandom),
            ($urandom_range(3) != 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
